// File: rtl/rvfi_multi_retire_tracker.sv
// rtl/rvfi_multi_retire_tracker.sv - multi-port RVFI retirement order/halt/watchdog tracker
//
// Assigns strictly increasing order numbers to up to NRET commits per cycle
// (channel 0 oldest), detects the halting self-loop commit, flags any commit
// retired after it, and runs a no-commit watchdog.
// Optional feature macro: RVFI_PC_CHECK_EN (PC continuity checker).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   commit          per-channel commit strobe (holes allowed)
//   pc_rdata        PC of committing instr, channel i at [32*i +: 32]
//   pc_wdata        next PC of committing instr
//   trap            committing instr trapped (never halts)
//   order           combinational order per channel, 0 where not committing
//   commit_count    registered running total of commits (wraps)
//   halt            sticky, set the cycle after the halting commit
//   halt_err        sticky, a commit retired after the halting instr
//   timeout         sticky, watchdog expired
//   pc_err          sticky PC discontinuity (0 without RVFI_PC_CHECK_EN)
//   pc_err_order    order of first discontinuous commit

module rvfi_multi_retire_tracker #(
  parameter int NRET    = 2,
  parameter int ORDER_W = 64,
  parameter int TIMEOUT = 10000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRET-1:0]           commit,
  input  logic [NRET*32-1:0]        pc_rdata,
  input  logic [NRET*32-1:0]        pc_wdata,
  input  logic [NRET-1:0]           trap,
  output logic [NRET*ORDER_W-1:0]   order,
  output logic [ORDER_W-1:0]        commit_count,
  output logic                      halt,
  output logic                      halt_err,
  output logic                      timeout,
  output logic                      pc_err,
  output logic [ORDER_W-1:0]        pc_err_order
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state;
  logic [WD_W-1:0]    wd;
  logic [ORDER_W-1:0] acc;
  logic               halt_hit;
  logic               younger;

  // Running prefix count gives each committing channel its order. younger is
  // evaluated before halt_hit is updated so it only sees channels above the
  // lowest halting one.
  always_comb begin
    acc      = commit_count;
    order    = '0;
    halt_hit = 1'b0;
    younger  = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (commit[i]) begin
        order[ORDER_W*i +: ORDER_W] = acc;
        acc = acc + ORDER_W'(1);
        if (halt_hit)
          younger = 1'b1;
        if (!trap[i] && pc_rdata[32*i +: 32] == pc_wdata[32*i +: 32])
          halt_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      commit_count <= '0;
      halt         <= 1'b0;
      halt_err     <= 1'b0;
      timeout      <= 1'b0;
      wd           <= '0;
    end else begin
      commit_count <= acc;
      case (state)
        RUN: begin
          if (halt_hit) begin
            state <= HALTED;
            halt  <= 1'b1;
            if (younger)
              halt_err <= 1'b1;
          end
          if (TIMEOUT > 0) begin
            if (|commit) begin
              wd <= '0;
            end else if (wd != WD_MAX) begin
              wd <= wd + WD_W'(1);
              if (wd == WD_MAX - WD_W'(1))
                timeout <= 1'b1;
            end
          end
        end
        HALTED: begin
          // Watchdog frozen; any further retirement is an error.
          if (|commit)
            halt_err <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef RVFI_PC_CHECK_EN
  logic [31:0]        exp_pc;
  logic               exp_valid;
  logic [31:0]        chain_pc;
  logic               chain_valid;
  logic               mis;
  logic [ORDER_W-1:0] mis_order;

  // Each committed channel must continue from the previous committed channel
  // in this cycle, or from the last cycle's final next-PC.
  always_comb begin
    chain_pc    = exp_pc;
    chain_valid = exp_valid;
    mis         = 1'b0;
    mis_order   = '0;
    for (int i = 0; i < NRET; i++) begin
      if (commit[i]) begin
        if (chain_valid && !mis && pc_rdata[32*i +: 32] != chain_pc) begin
          mis       = 1'b1;
          mis_order = order[ORDER_W*i +: ORDER_W];
        end
        chain_pc    = pc_wdata[32*i +: 32];
        chain_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_pc       <= '0;
      exp_valid    <= 1'b0;
      pc_err       <= 1'b0;
      pc_err_order <= '0;
    end else begin
      exp_pc    <= chain_pc;
      exp_valid <= chain_valid;
      if (mis) begin
        pc_err <= 1'b1;
        if (!pc_err)
          pc_err_order <= mis_order;
      end
    end
  end
`else
  assign pc_err       = 1'b0;
  assign pc_err_order = '0;
`endif

endmodule
